// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the SPI front end of the AES cores.
// Holds the frame-phase enum, the command byte layout and the key-code decode.
package aes_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    KEY,
    MSG,
    CALC,
    TX,
    DONE,
    ERR
  } state_e;

  // Bit positions inside the 8-bit command byte (MSB first on the wire).
  localparam int CMD_MODE_BIT = 7;
  localparam int CMD_KEY_HI   = 6;
  localparam int CMD_KEY_LO   = 5;

  localparam logic [1:0] KEY_CODE_128  = 2'b00;
  localparam logic [1:0] KEY_CODE_192  = 2'b01;
  localparam logic [1:0] KEY_CODE_256  = 2'b10;
  localparam logic [1:0] KEY_CODE_RSVD = 2'b11;

  function automatic logic [15:0] key_len_bits(input logic [1:0] code);
    case (code)
      KEY_CODE_128: key_len_bits = 16'd128;
      KEY_CODE_192: key_len_bits = 16'd192;
      default:      key_len_bits = 16'd256;
    endcase
  endfunction

endpackage

// File: rtl/aes_spi_crypto_node_shift_reg.sv
// Generic left-shifting register: parallel load wins over serial shift.
// Used for the received key, the received block and the transmit result.
module aes_spi_shift_reg
  import aes_spi_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift_en) begin
      q <= {q[W-2:0], sin};
    end
  end

endmodule

// File: rtl/aes_spi_crypto_node.sv
// SPI subnode: receives CMD | KEY | MSG, drives the AES cores, waits CORE_LAT
// cycles, then returns the selected core result MSB first on sdo.
module aes_spi_crypto_node
  import aes_spi_pkg::*;
#(
  parameter int  NB       = 4,
  parameter int  NK_MAX   = 8,
  parameter int  CORE_LAT = 1,
  localparam int BLK_W    = 32 * NB,
  localparam int KEY_W    = 32 * NK_MAX
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic             cs_n,
  input  logic             sdi,
  output logic             sdo,
  input  logic [BLK_W-1:0] enc_result,
  input  logic [BLK_W-1:0] dec_result,
  output logic [BLK_W-1:0] to_core_msg,
  output logic [KEY_W-1:0] to_core_key,
  output logic [1:0]       key_len,
  output logic             mode,
  output logic             busy,
  output logic             result_valid,
  output logic             frame_err,
  output state_e           dbg_state
);

  localparam int CNT_MAX_A = (KEY_W > BLK_W) ? KEY_W : BLK_W;
  localparam int CNT_MAX   = (CNT_MAX_A > CORE_LAT) ? CNT_MAX_A : CORE_LAT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLK_W - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(CORE_LAT - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       cmd_q;
  logic [1:0]       cmd_code;
  logic [15:0]      kbits;
  logic [CNT_W-1:0] key_last;
  logic             active;
  logic             cmd_done, key_done, msg_done, calc_done, tx_done;
  logic             key_load, key_shift, msg_shift, tx_load, tx_shift;
  logic [KEY_W-1:0] key_shifted, key_aligned, key_load_val;
  logic [BLK_W-1:0] tx_q, result_sel;

  // cs_n is the only flow control: every cycle it is low carries one bit.
  // result_valid is a single-cycle strobe, raised on the edge the result is latched.
  assign active    = !cs_n;
  assign dbg_state = state;

  // When the 8th command bit is on sdi, byte bit b sits at cmd_q[b-1].
  assign cmd_code = cmd_q[CMD_KEY_HI-1:CMD_KEY_LO-1];
  assign kbits    = key_len_bits(key_len);
  assign key_last = CNT_W'(kbits - 16'd1);

  assign cmd_done  = active && (state == CMD)  && (cnt == CMD_LAST);
  assign key_done  = active && (state == KEY)  && (cnt == key_last);
  assign msg_done  = active && (state == MSG)  && (cnt == BLK_LAST);
  assign calc_done = active && (state == CALC) && (cnt == LAT_LAST);
  assign tx_done   = active && (state == TX)   && (cnt == BLK_LAST);

  // Short keys arrive right-justified; the final bit moves them to the top.
  assign key_shifted  = {to_core_key[KEY_W-2:0], sdi};
  assign key_aligned  = key_shifted << (16'(KEY_W) - kbits);
  assign key_load     = key_done || (cmd_done && (cmd_code != KEY_CODE_RSVD));
  assign key_load_val = key_done ? key_aligned : '0;
  assign key_shift    = active && (state == KEY);

  assign msg_shift  = active && (state == MSG);
  assign result_sel = mode ? dec_result : enc_result;
  assign tx_load    = calc_done;
  assign tx_shift   = active && (state == TX);

  assign sdo = (state == TX) ? tx_q[BLK_W-1] : 1'b0;

  aes_spi_shift_reg #(.W(KEY_W)) u_key_sr (
    .clk      (in_clk),
    .rst      (rst),
    .load     (key_load),
    .load_val (key_load_val),
    .shift_en (key_shift),
    .sin      (sdi),
    .q        (to_core_key)
  );

  aes_spi_shift_reg #(.W(BLK_W)) u_msg_sr (
    .clk      (in_clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val ('0),
    .shift_en (msg_shift),
    .sin      (sdi),
    .q        (to_core_msg)
  );

  aes_spi_shift_reg #(.W(BLK_W)) u_tx_sr (
    .clk      (in_clk),
    .rst      (rst),
    .load     (tx_load),
    .load_val (result_sel),
    .shift_en (tx_shift),
    .sin      (1'b0),
    .q        (tx_q)
  );

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cmd_q        <= '0;
      key_len      <= '0;
      mode         <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if ((state != IDLE) && cs_n) begin
        // Abort: core inputs and frame_err are deliberately left untouched.
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (active) begin
            cmd_q     <= {6'b0, sdi};
            cnt       <= CNT_W'(1);
            frame_err <= 1'b0;
            busy      <= 1'b1;
            state     <= CMD;
          end
          CMD: begin
            cmd_q <= {cmd_q[5:0], sdi};
            cnt   <= cnt + 1'b1;
            if (cmd_done) begin
              cnt <= '0;
              if (cmd_code == KEY_CODE_RSVD) begin
                frame_err <= 1'b1;
                busy      <= 1'b0;
                state     <= ERR;
              end else begin
                mode    <= cmd_q[CMD_MODE_BIT-1];
                key_len <= cmd_code;
                state   <= KEY;
              end
            end
          end
          KEY: if (key_done) begin
            cnt   <= '0;
            state <= MSG;
          end else begin
            cnt <= cnt + 1'b1;
          end
          MSG: if (msg_done) begin
            cnt   <= '0;
            state <= CALC;
          end else begin
            cnt <= cnt + 1'b1;
          end
          CALC: if (calc_done) begin
            cnt          <= '0;
            result_valid <= 1'b1;
            state        <= TX;
          end else begin
            cnt <= cnt + 1'b1;
          end
          TX: if (tx_done) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
          DONE:    busy <= 1'b0;
          ERR:     busy <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_spi_crypto_node.sv
// Bench for aes_spi_crypto_node: known AES vectors through a core stub,
// reserved key code, aborts, random back-to-back frames, CORE_LAT=4 and async reset.
`timescale 1ns/1ps
module tb_aes_spi_crypto_node;
  import aes_spi_pkg::*;

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0, rst = 1'b1, cs_n = 1'b1, cs4_n = 1'b1, sdi = 1'b0;
  logic sdo1, busy1, rv1, ferr1, mode1;
  logic sdo4, busy4, rv4, ferr4, mode4;
  logic [1:0] klen1, klen4;
  logic [127:0] msg1, enc1, dec1, msg4, enc4, dec4;
  logic [255:0] key1, key4;
  state_e st1, st4;

  int checks = 0;
  int failures = 0;
  int rv_cnt1 = 0;
  int rv_cnt4 = 0;
  logic [127:0] exp_q[$];

  // clock / reset / core stub
  always #5 clk = ~clk;

  function automatic logic [127:0] ref_core(input logic dec, input logic [127:0] m, input logic [255:0] k);
    if (!dec) begin
      if (m == PT && k == K128) return C128;
      if (m == PT && k == K192) return C192;
      if (m == PT && k == K256) return C256;
    end else begin
      if (m == C128 && k == K128) return PT;
      if (m == C192 && k == K192) return PT;
      if (m == C256 && k == K256) return PT;
    end
    return {m[126:0], m[127]} ^ k[255:128] ^ k[127:0] ^
           (dec ? 128'hf0f0_1234_0f0f_5678_aaaa_5555_c3c3_9999 : 128'h3c3c_8765_a5a5_4321_0ff0_f00f_6969_1111);
  endfunction

  assign enc1 = ref_core(1'b0, msg1, key1);
  assign dec1 = ref_core(1'b1, msg1, key1);

  // Latency-4 core: result reflects inputs only after three pipeline stages.
  logic [127:0] pm[3] = '{default: '0};
  logic [255:0] pk[3] = '{default: '0};
  always @(posedge clk) begin
    pm[0] <= msg4; pm[1] <= pm[0]; pm[2] <= pm[1];
    pk[0] <= key4; pk[1] <= pk[0]; pk[2] <= pk[1];
  end
  assign enc4 = ref_core(1'b0, pm[2], pk[2]);
  assign dec4 = ref_core(1'b1, pm[2], pk[2]);

  always @(negedge clk) begin
    if (rv1 === 1'b1) rv_cnt1++;
    if (rv4 === 1'b1) rv_cnt4++;
  end

  aes_spi_crypto_node dut1 (
    .in_clk(clk), .rst(rst), .cs_n(cs_n), .sdi(sdi), .sdo(sdo1),
    .enc_result(enc1), .dec_result(dec1), .to_core_msg(msg1), .to_core_key(key1),
    .key_len(klen1), .mode(mode1), .busy(busy1), .result_valid(rv1),
    .frame_err(ferr1), .dbg_state(st1)
  );

  aes_spi_crypto_node #(.CORE_LAT(4)) dut4 (
    .in_clk(clk), .rst(rst), .cs_n(cs4_n), .sdi(sdi), .sdo(sdo4),
    .enc_result(enc4), .dec_result(dec4), .to_core_msg(msg4), .to_core_key(key4),
    .key_len(klen4), .mode(mode4), .busy(busy4), .result_valid(rv4),
    .frame_err(ferr4), .dbg_state(st4)
  );

  // driver tasks
  task automatic drive_bits(input bit sel, input logic [255:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel) cs4_n = 1'b0; else cs_n = 1'b0;
      sdi = data[255-i];
    end
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] cmd, input logic [255:0] key,
                            input int kbits, input logic [127:0] msg);
    drive_bits(sel, {cmd, 248'h0}, 8);
    drive_bits(sel, key, kbits);
    drive_bits(sel, {msg, 128'h0}, 128);
  endtask

  task automatic wait_result(input bit sel, input int lat, input string name, output bit ok);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    while (cyc < lat + 20 && !seen) begin
      @(negedge clk);
      sdi = 1'($urandom_range(0, 1));
      cyc++;
      seen = sel ? (rv4 === 1'b1) : (rv1 === 1'b1);
    end
    checks++;
    if (!seen || cyc != lat + 1) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles (seen=%0b), expected %0d", name, cyc, seen, lat + 1);
    end
    ok = seen;
  endtask

  task automatic read_tx(input bit sel, input string name);
    logic [127:0] got, exp;
    for (int i = 0; i < 128; i++) begin
      if (i > 0) @(negedge clk);
      sdi = 1'($urandom_range(0, 1));
      got[127-i] = sel ? sdo4 : sdo1;
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_result: got %h, no expected entry queued", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL %s_result: got %h, expected %h", name, got, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ((sel ? busy4 : busy1) !== 1'b0 || (sel ? sdo4 : sdo1) !== 1'b0 || (sel ? st4 : st1) !== DONE) begin
      failures++;
      $display("FAIL %s_done: busy=%b sdo=%b state=%0d, expected 0 0 %0d",
               name, sel ? busy4 : busy1, sel ? sdo4 : sdo1, sel ? st4 : st1, DONE);
    end
    if (sel) cs4_n = 1'b1; else cs_n = 1'b1;
    @(negedge clk);
    checks++;
    if ((sel ? st4 : st1) !== IDLE) begin
      failures++;
      $display("FAIL %s_idle: state=%0d, expected %0d", name, sel ? st4 : st1, IDLE);
    end
  endtask

  task automatic run_frame(input bit sel, input logic [7:0] cmd, input logic [255:0] key, input int kbits,
                           input logic [127:0] msg, input int lat, input string name);
    int rv_before;
    bit ok;
    rv_before = sel ? rv_cnt4 : rv_cnt1;
    send_frame(sel, cmd, key, kbits, msg);
    checks++;
    if ((sel ? busy4 : busy1) !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy: got %b, expected 1", name, sel ? busy4 : busy1);
    end
    wait_result(sel, lat, name, ok);
    if (ok) begin
      read_tx(sel, name);
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (sel) cs4_n = 1'b1; else cs_n = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ((sel ? rv_cnt4 : rv_cnt1) - rv_before != 1) begin
      failures++;
      $display("FAIL %s_rv_count: got %0d pulses, expected 1", name, (sel ? rv_cnt4 : rv_cnt1) - rv_before);
    end
  endtask

  // scenarios
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({sdo1, busy1, rv1, ferr1, mode1, klen1, msg1, key1} !== '0 || st1 !== IDLE) begin
      failures++;
      $display("FAIL reset_dut1: outputs=%h state=%0d, expected 0 IDLE",
               {sdo1, busy1, rv1, ferr1, mode1, klen1}, st1);
    end
    checks++;
    if ({sdo4, busy4, rv4, ferr4, mode4, klen4, msg4, key4} !== '0 || st4 !== IDLE) begin
      failures++;
      $display("FAIL reset_dut4: outputs=%h state=%0d, expected 0 IDLE",
               {sdo4, busy4, rv4, ferr4, mode4, klen4}, st4);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_aes128_enc();
    exp_q.push_back(C128);
    run_frame(1'b0, 8'h00, K128, 128, PT, 1, "aes128_enc");
    checks++;
    if (klen1 !== 2'b00 || mode1 !== 1'b0) begin
      failures++;
      $display("FAIL aes128_cfg: key_len=%b mode=%b, expected 00 0", klen1, mode1);
    end
  endtask

  task automatic test_aes256_dec();
    exp_q.push_back(PT);
    run_frame(1'b0, 8'hC0, K256, 256, C256, 1, "aes256_dec");
    checks++;
    if (key1 !== K256 || klen1 !== 2'b10 || mode1 !== 1'b1) begin
      failures++;
      $display("FAIL aes256_cfg: key=%h key_len=%b mode=%b, expected %h 10 1", key1, klen1, mode1, K256);
    end
  endtask

  task automatic test_aes192_enc();
    exp_q.push_back(C192);
    run_frame(1'b0, 8'h20, K192, 192, PT, 1, "aes192_enc");
    checks++;
    if (key1 !== K192 || key1[63:0] !== 64'h0 || klen1 !== 2'b01) begin
      failures++;
      $display("FAIL aes192_key: key=%h key_len=%b, expected %h 01", key1, klen1, K192);
    end
  endtask

  task automatic test_reserved();
    drive_bits(1'b0, {8'h60, 248'h0}, 8);
    @(negedge clk);
    checks++;
    if (ferr1 !== 1'b1 || busy1 !== 1'b0 || sdo1 !== 1'b0 || st1 !== ERR) begin
      failures++;
      $display("FAIL reserved_err: frame_err=%b busy=%b sdo=%b state=%0d, expected 1 0 0 %0d",
               ferr1, busy1, sdo1, st1, ERR);
    end
    for (int i = 0; i < 5; i++) begin
      sdi = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (sdo1 !== 1'b0 || st1 !== ERR || busy1 !== 1'b0) begin
        failures++;
        $display("FAIL reserved_hold: sdo=%b state=%0d busy=%b, expected 0 %0d 0", sdo1, st1, busy1, ERR);
      end
    end
    cs_n = 1'b1;
    @(negedge clk);
    checks++;
    if (st1 !== IDLE || ferr1 !== 1'b1 || klen1 !== 2'b01) begin
      failures++;
      $display("FAIL reserved_sticky: state=%0d frame_err=%b key_len=%b, expected %0d 1 01", st1, ferr1, klen1, IDLE);
    end
    exp_q.push_back(C128);
    drive_bits(1'b0, {8'h00, 248'h0}, 1);
    @(negedge clk);
    checks++;
    if (ferr1 !== 1'b0 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL reserved_clear: frame_err=%b busy=%b, expected 0 1", ferr1, busy1);
    end
    sdi = 1'b0;
    drive_bits(1'b0, 256'h0, 6);
    drive_bits(1'b0, K128, 128);
    drive_bits(1'b0, {PT, 128'h0}, 128);
    begin
      bit ok;
      wait_result(1'b0, 1, "after_reserved", ok);
      if (ok) read_tx(1'b0, "after_reserved");
      else begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        cs_n = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_abort();
    int rv_before;
    rv_before = rv_cnt1;
    drive_bits(1'b0, {8'hC0, 248'h0}, 8);
    drive_bits(1'b0, K256, 50);
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    checks++;
    if (st1 !== IDLE || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL abort_key: state=%0d busy=%b, expected %0d 0", st1, busy1, IDLE);
    end
    send_frame(1'b0, 8'h00, K128, 128, PT);
    @(negedge clk);
    checks++;
    if (st1 !== CALC || sdo1 !== 1'b0) begin
      failures++;
      $display("FAIL abort_calc_entry: state=%0d sdo=%b, expected %0d 0", st1, sdo1, CALC);
    end
    cs_n = 1'b1;
    @(negedge clk);
    checks++;
    if (st1 !== IDLE || busy1 !== 1'b0 || rv_cnt1 != rv_before) begin
      failures++;
      $display("FAIL abort_calc: state=%0d busy=%b rv_pulses=%0d, expected %0d 0 0",
               st1, busy1, rv_cnt1 - rv_before, IDLE);
    end
    exp_q.push_back(C128);
    run_frame(1'b0, 8'h00, K128, 128, PT, 1, "after_abort");
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      logic mode;
      logic [1:0] code;
      int kbits;
      logic [255:0] raw, mask, key;
      logic [127:0] msg;
      logic [7:0] cmd;
      mode = 1'($urandom_range(0, 1));
      code = 2'($urandom_range(0, 2));
      kbits = 128 + 64 * int'(code);
      for (int w = 0; w < 8; w++) raw[w*32 +: 32] = $urandom;
      for (int w = 0; w < 4; w++) msg[w*32 +: 32] = $urandom;
      mask = '1;
      mask = mask << (256 - kbits);
      key = raw & mask;
      cmd = {mode, code, 5'($urandom_range(0, 31))};
      exp_q.push_back(ref_core(mode, msg, key));
      run_frame(1'b0, cmd, key, kbits, msg, 1, "b2b");
      checks++;
      if (key1 !== key || klen1 !== code || mode1 !== mode) begin
        failures++;
        $display("FAIL b2b_cfg: key=%h key_len=%b mode=%b, expected %h %b %b", key1, klen1, mode1, key, code, mode);
      end
    end
  endtask

  task automatic test_lat4_reset();
    bit ok;
    exp_q.push_back(C128);
    run_frame(1'b1, 8'h00, K128, 128, PT, 4, "lat4");
    send_frame(1'b1, 8'h00, K128, 128, PT);
    wait_result(1'b1, 4, "lat4_rst", ok);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({sdo4, busy4, rv4, ferr4, mode4, klen4, msg4, key4} !== '0 || st4 !== IDLE) begin
      failures++;
      $display("FAIL lat4_async_reset: outputs=%h msg=%h state=%0d, expected 0 IDLE",
               {sdo4, busy4, rv4, ferr4, mode4, klen4}, msg4, st4);
    end
    @(negedge clk);
    cs4_n = 1'b1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_aes128_enc();
    test_aes256_dec();
    test_aes192_enc();
    test_reserved();
    test_abort();
    test_back_to_back();
    test_lat4_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
